// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM states and the fetch buffer entry.
package cpu_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_END,
      S_FAULT
   } fetch_state_t;

   localparam int INST_BYTES = 4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {inst, pc} entries.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_pop;
   logic w_push;

   assign full  = (r_cnt == (AW+1)'(DEPTH));
   assign empty = (r_cnt == '0);
   assign dout  = r_mem[r_rd];

   // A full buffer still accepts a push when the head leaves this cycle
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wr] <= din;
   end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads inst_memory and
// feeds decode through a small buffer with valid/ready handshake.
module inst_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int          MEM_BYTES = 32,
   parameter int          BUF_DEPTH = 2,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] im_addr,
   output logic        im_en,
   input  logic [31:0] im_inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   output logic        done,
   output logic        fault
);

   localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INST_BYTES);

   fetch_state_t r_state;
   fetch_state_t w_state_nx;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nx;

   logic         w_flush;
   logic         w_push;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic         w_redir_ok;
   logic         w_redir_bad;
   fetch_entry_t w_din;
   fetch_entry_t w_head;

   assign w_redir_ok  = redir_valid && (redir_pc[1:0] == 2'b00);
   assign w_redir_bad = redir_valid && (redir_pc[1:0] != 2'b00);
   assign w_din       = '{inst: im_inst, pc: r_pc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
      end
   end

   // Redirects outrank capture; the range check stops fetch before wrap
   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_flush    = 1'b0;
      w_push     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_redir_bad) begin
               w_state_nx = S_FAULT;
               w_flush    = 1'b1;
            end else if (w_redir_ok) begin
               w_pc_nx = redir_pc;
               w_flush = 1'b1;
            end else if (start) begin
               w_state_nx = S_FETCH;
            end
         end
         S_FETCH: begin
            if (w_redir_bad) begin
               w_state_nx = S_FAULT;
               w_flush    = 1'b1;
            end else if (w_redir_ok) begin
               w_pc_nx = redir_pc;
               w_flush = 1'b1;
            end else if (r_pc > LAST_PC) begin
               w_state_nx = S_END;
            end else if (!w_full || (out_valid && out_ready)) begin
               w_push  = 1'b1;
               w_pc_nx = r_pc + 32'(INST_BYTES);
            end
         end
         S_END: begin
            if (w_redir_bad) begin
               w_state_nx = S_FAULT;
               w_flush    = 1'b1;
            end else if (w_redir_ok) begin
               w_state_nx = S_FETCH;
               w_pc_nx    = redir_pc;
               w_flush    = 1'b1;
            end
         end
         S_FAULT: begin
            w_state_nx = S_FAULT;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   assign w_pop = out_valid && out_ready && !w_flush;

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (w_flush),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   assign im_addr   = r_pc;
   assign im_en     = w_push;
   assign out_valid = !w_empty;
   assign out_inst  = out_valid ? w_head.inst : 32'h0;
   assign out_pc    = out_valid ? w_head.pc : 32'h0;
   assign done      = (r_state == S_END) && w_empty;
   assign fault     = (r_state == S_FAULT);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl against a combinational program image.
module tb_inst_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] im_addr;
   logic        im_en;
   logic [31:0] im_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        done;
   logic        fault;

   logic [31:0] img [8];
   int          n_chk;
   int          n_pass;
   int          n_oob;

   inst_fetch_ctrl #(
      .MEM_BYTES (32),
      .BUF_DEPTH (2),
      .RESET_PC  (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .im_addr     (im_addr),
      .im_en       (im_en),
      .im_inst     (im_inst),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .done        (done),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      if (im_addr < 32'd32) im_inst = img[im_addr[4:2]];
      else                  im_inst = 32'hBAD0BAD0;
   end

   always @(posedge clk) begin
      if (im_en && im_addr > 32'd28) n_oob <= n_oob + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 1 after a start pulse
   task automatic restart(input logic rdy);
      out_ready   = rdy;
      redir_valid = 1'b0;
      redir_pc    = 32'h0;
      rst         = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      img = '{32'h01230000, 32'h14150000, 32'hF0B7AB1E, 32'hD07B0005,
              32'h36B40000, 32'h0, 32'h0, 32'h0};
      n_chk       = 0;
      n_pass      = 0;
      n_oob       = 0;
      rst         = 1'b1;
      start       = 1'b0;
      out_ready   = 1'b0;
      redir_valid = 1'b0;
      redir_pc    = 32'h0;

      // reset state
      #3;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_inst", out_inst, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_en", 32'(im_en), 32'h0);
      chk("rst_addr", im_addr, 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);

      // streaming
      restart(1'b1);
      chk("st_c1_valid", 32'(out_valid), 32'h0);
      chk("st_c1_en", 32'(im_en), 32'h1);
      tick();
      for (int k = 0; k < 8; k++) begin
         chk("st_valid", 32'(out_valid), 32'h1);
         chk("st_pc", out_pc, 32'(4 * k));
         chk("st_inst", out_inst, img[k]);
         tick();
      end
      chk("st_end_valid", 32'(out_valid), 32'h0);
      chk("st_done", 32'(done), 32'h1);
      chk("st_end_en", 32'(im_en), 32'h0);

      // backpressure
      restart(1'b0);
      tick();
      chk("bp_c2_en", 32'(im_en), 32'h1);
      for (int c = 2; c < 7; c++) begin
         chk("bp_valid", 32'(out_valid), 32'h1);
         chk("bp_pc", out_pc, 32'h0);
         chk("bp_inst", out_inst, 32'h01230000);
         if (c > 2) begin
            chk("bp_en", 32'(im_en), 32'h0);
            chk("bp_addr", im_addr, 32'h8);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_pc", out_pc, 32'h0);
      chk("bp_rel_en", 32'(im_en), 32'h1);
      tick();
      chk("bp_next_pc", out_pc, 32'h4);
      chk("bp_next_inst", out_inst, 32'h14150000);
      tick();
      chk("bp_third_pc", out_pc, 32'h8);

      // redirect mid-stream
      restart(1'b1);
      tick();
      tick();
      chk("rd_head_pc", out_pc, 32'h4);
      redir_valid = 1'b1;
      redir_pc    = 32'd12;
      tick();
      redir_valid = 1'b0;
      chk("rd_flush_valid", 32'(out_valid), 32'h0);
      tick();
      chk("rd_tgt_valid", 32'(out_valid), 32'h1);
      chk("rd_tgt_pc", out_pc, 32'd12);
      chk("rd_tgt_inst", out_inst, 32'hD07B0005);
      tick();
      chk("rd_after_pc", out_pc, 32'd16);
      chk("rd_after_inst", out_inst, 32'h36B40000);

      // redirect in same cycle as a full-buffer pop
      restart(1'b0);
      tick();
      tick();
      chk("sim_full_en", 32'(im_en), 32'h0);
      out_ready   = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = 32'd16;
      #1;
      chk("sim_redir_en", 32'(im_en), 32'h0);
      tick();
      redir_valid = 1'b0;
      chk("sim_flush_valid", 32'(out_valid), 32'h0);
      tick();
      chk("sim_tgt_pc", out_pc, 32'd16);
      chk("sim_tgt_inst", out_inst, 32'h36B40000);

      // misaligned redirect
      restart(1'b1);
      tick();
      redir_valid = 1'b1;
      redir_pc    = 32'd6;
      tick();
      redir_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("mis_fault", 32'(fault), 32'h1);
         chk("mis_valid", 32'(out_valid), 32'h0);
         chk("mis_en", 32'(im_en), 32'h0);
         chk("mis_addr", im_addr, 32'h4);
         tick();
      end
      rst = 1'b1;
      #1;
      chk("mis_rst_fault", 32'(fault), 32'h0);
      rst = 1'b0;

      // async reset between edges
      restart(1'b1);
      tick();
      tick();
      chk("ar_pre_valid", 32'(out_valid), 32'h1);
      chk("ar_pre_pc", out_pc, 32'h4);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 32'(out_valid), 32'h0);
      chk("ar_pc", out_pc, 32'h0);
      chk("ar_inst", out_inst, 32'h0);
      chk("ar_en", 32'(im_en), 32'h0);
      chk("ar_addr", im_addr, 32'h0);
      restart(1'b1);
      tick();
      chk("ar_re_valid", 32'(out_valid), 32'h1);
      chk("ar_re_pc", out_pc, 32'h0);
      chk("ar_re_inst", out_inst, 32'h01230000);

      tick();
      chk("no_oob_fetch", 32'(n_oob), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
